// File: rtl/multi_byte_add_pkg.sv
// multi_byte_add_pkg
// Shared definitions for the multi-byte add arbiter slice:
//   state_t     - sequencer states (IDLE, RUN, DONE)
//   BYTE_W      - width of the shared adder slice
//   NBYTES_MIN  - smallest legal operand width in bytes
//   NBYTES_MAX  - largest legal operand width in bytes
package multi_byte_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int BYTE_W     = 8;
  localparam int NBYTES_MIN = 1;
  localparam int NBYTES_MAX = 16;

endpackage

// File: rtl/rca8_slice.sv
// rca8_slice
// Purely combinational 8-bit ripple-carry adder. This is the single shared
// arithmetic slice that the arbiter feeds one byte per cycle.
// Ports:
//   a, b  in  BYTE_W  addend bytes
//   cin   in  1       carry into bit 0
//   sum   out BYTE_W  sum byte
//   cout  out 1       carry out of bit BYTE_W-1
module rca8_slice
  import multi_byte_add_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W:0] carry;

  assign carry[0] = cin;

  // One full adder per bit; each stage's carry feeds the next stage.
  for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[BYTE_W];

endmodule

// File: rtl/multi_byte_add_arbiter.sv
// multi_byte_add_arbiter
// Shares one 8-bit ripple-carry slice between two requesters. A granted
// request's 8*NBYTES-bit operands are summed LSB byte first, one byte per
// cycle, with the carry registered between bytes. The result, carry-out and
// owning requester id are returned on a single valid/ready response port.
//
// Optional feature macro: MULTI_ADD_SUB_EN
//   defined   - reqN_sub=1 computes a - b (b inverted, byte-0 carry-in 1,
//               rsp_cout=1 means no borrow)
//   undefined - reqN_sub is ignored; add only
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   reqN_valid / reqN_ready      request handshake, N = 0, 1
//   reqN_a, reqN_b               8*NBYTES-bit operands
//   reqN_cin                     carry into byte 0
//   reqN_sub                     subtract select (MULTI_ADD_SUB_EN only)
//   rsp_valid / rsp_ready        response handshake
//   rsp_id                       requester owning the response
//   rsp_sum, rsp_cout            result and carry out of the top byte
module multi_byte_add_arbiter
  import multi_byte_add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [8*NBYTES-1:0]    req0_a,
  input  logic [8*NBYTES-1:0]    req0_b,
  input  logic                   req0_cin,
  input  logic                   req0_sub,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [8*NBYTES-1:0]    req1_a,
  input  logic [8*NBYTES-1:0]    req1_b,
  input  logic                   req1_cin,
  input  logic                   req1_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [8*NBYTES-1:0]    rsp_sum,
  output logic                   rsp_cout
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  // Elaboration-time guard on the operand width.
  if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX) begin : g_bad_nbytes
    $error("multi_byte_add_arbiter: NBYTES out of range");
  end

  state_t            state;
  logic              rr;
  logic [IDX_W-1:0]  idx;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic              cin_q;
  logic              carry_q;

  logic              grant0;
  logic              grant1;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] sum_byte;
  logic              slice_cin;
  logic              slice_cout;

`ifdef MULTI_ADD_SUB_EN
  logic              sub_q;
`else
  logic              sub_unused;
  assign sub_unused = req0_sub ^ req1_sub;
`endif

  // Round-robin arbitration: a lone requester always wins; on contention
  // the requester named by rr wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || !rr);
    grant1 = req1_valid && (!req0_valid ||  rr);
  end

  // Readiness is gated by rst_n so nothing can appear accepted during reset.
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;

  // Select the current operand bytes and the carry feeding the slice.
  // Byte 0 takes the request's carry-in, later bytes the registered carry.
  always_comb begin
    a_byte    = a_q[idx*BYTE_W +: BYTE_W];
    b_byte    = b_q[idx*BYTE_W +: BYTE_W];
    slice_cin = (idx == '0) ? cin_q : carry_q;
`ifdef MULTI_ADD_SUB_EN
    // Two's-complement subtract: invert b and inject a 1 at byte 0.
    if (sub_q) begin
      b_byte = ~b_byte;
      if (idx == '0) begin
        slice_cin = 1'b1;
      end
    end
`endif
  end

  rca8_slice u_slice (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (slice_cin),
    .sum  (sum_byte),
    .cout (slice_cout)
  );

  // Sequencer: latch a granted request, walk the bytes, then hold the
  // result until the consumer takes it. On entry to DONE the last byte has
  // just been written, and rsp_valid is raised on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= 1'b0;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
`ifdef MULTI_ADD_SUB_EN
      sub_q     <= 1'b0;
`endif
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            a_q    <= req1_ready ? req1_a   : req0_a;
            b_q    <= req1_ready ? req1_b   : req0_b;
            cin_q  <= req1_ready ? req1_cin : req0_cin;
`ifdef MULTI_ADD_SUB_EN
            sub_q  <= req1_ready ? req1_sub : req0_sub;
`endif
            rsp_id <= req1_ready;
            // Priority passes to the requester that was not just served.
            rr     <= ~req1_ready;
            idx    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          rsp_sum[idx*BYTE_W +: BYTE_W] <= sum_byte;
          carry_q <= slice_cout;
          if (idx == LAST_IDX) begin
            rsp_cout <= slice_cout;
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
